// File: rtl/spi_boot_loader.sv
// Boot sequencer that drives the impl_axi SPI-to-AXI command port: holds the core in
// reset, writes N program words to base_addr+k with a status poll after each, then releases it.
module spi_boot_loader #(
  parameter int sword    = 32,
  parameter int NWORDS_W = 10,
  parameter int SCLK_DIV = 2,
  parameter int GAP_PER  = 4,
  parameter int MAX_POLL = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [NWORDS_W-1:0] i_nwords,
  input  logic [sword-1:0]    i_base_addr,
  output logic [NWORDS_W-1:0] o_mem_addr,
  input  logic [sword-1:0]    i_mem_rdata,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output logic [NWORDS_W-1:0] o_err_index,
  output logic                o_spi_CEB,
  output logic                o_spi_SCLK,
  output logic                o_spi_DATA,
  input  logic                i_spi_DOUT
);
  localparam int FW = 2*sword + 2;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GW = (GAP_PER > 1) ? $clog2(GAP_PER) : 1;
  localparam int PW = $clog2(MAX_POLL + 1);
  localparam int BW = $clog2(FW + 1);

  typedef enum logic [2:0] {S_IDLE, S_FRAME, S_GAP, S_DONE, S_ERR} state_t;
  typedef enum logic [1:0] {K_RST_LO, K_WR, K_POLL, K_RST_HI} kind_t;

  state_t r_state, w_next;
  kind_t  r_kind, w_nkind;
  logic [NWORDS_W-1:0] r_nwords, r_k, r_mem_addr, r_err_index, w_k1;
  logic [sword-1:0]    r_base, r_wdata, w_addr;
  logic [PW-1:0]       r_poll;
  logic [1:0]          r_status, r_fetch;
  logic [FW-1:0]       r_sh, w_frame;
  logic [BW-1:0]       r_bitcnt, w_len;
  logic [DW-1:0]       r_div;
  logic [GW-1:0]       r_gap;
  logic r_ceb, r_sclk;
  logic w_tick, w_rise, w_fall, w_frame_end, w_gap_end, w_accept, w_st_ok, w_last, w_poll_max;

  assign w_tick      = o_busy && (r_div == DW'(SCLK_DIV - 1));
  assign w_rise      = w_tick && !r_sclk;
  assign w_fall      = w_tick && r_sclk;
  assign w_len       = (r_kind == K_POLL) ? BW'(sword + 2) : BW'(FW);
  assign w_frame_end = (r_state == S_FRAME) && w_fall && (r_bitcnt == w_len);
  assign w_gap_end   = (r_state == S_GAP) && w_fall && (r_gap == GW'(GAP_PER - 1));
  assign w_accept    = i_start && !o_busy;
  assign w_st_ok     = (r_status == 2'b00);
  assign w_k1        = r_k + NWORDS_W'(1);
  assign w_last      = (w_k1 == r_nwords);
  assign w_poll_max  = ((r_poll + PW'(1)) == PW'(MAX_POLL));
  assign w_addr      = r_base + sword'(r_k);

  always_comb begin
    w_frame = '0;
    case (r_kind)
      K_WR:     w_frame = {2'b10, w_addr, r_wdata};
      K_RST_HI: w_frame = FW'(1);
      default:  w_frame = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_nkind = r_kind;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (i_start) w_next = S_FRAME;
      S_FRAME: if (w_frame_end) begin
        w_next = S_GAP;
        case (r_kind)
          K_RST_LO: w_nkind = (r_nwords == '0) ? K_RST_HI : K_WR;
          K_WR:     w_nkind = K_POLL;
          K_POLL:   if (w_st_ok) w_nkind = w_last ? K_RST_HI : K_WR;
                    else if (w_poll_max) w_next = S_ERR;
          K_RST_HI: w_next = S_DONE;
          default:  w_next = S_IDLE;
        endcase
      end
      S_GAP:   if (w_gap_end) w_next = S_FRAME;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_FRAME) || (r_state == S_GAP);
    o_done = (r_state == S_DONE);
    o_err  = (r_state == S_ERR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_kind <= K_RST_LO; r_nwords <= '0; r_base <= '0; r_k <= '0; r_poll <= '0;
      r_status <= '0; r_wdata <= '0; r_sh <= '0; r_bitcnt <= '0; r_div <= '0;
      r_gap <= '0; r_fetch <= '0; r_ceb <= 1'b1; r_sclk <= 1'b0;
      r_mem_addr <= '0; r_err_index <= '0;
    end else begin
      // mem_rdata is valid one CLK after mem_addr moves, so capture two edges later
      r_fetch <= {r_fetch[0], 1'b0};
      if (r_fetch[1]) r_wdata <= i_mem_rdata;
      if (o_busy) begin
        r_div <= w_tick ? '0 : r_div + DW'(1);
        if (w_tick) r_sclk <= ~r_sclk;
      end
      if (w_accept) begin
        r_nwords <= i_nwords; r_base <= i_base_addr; r_k <= '0; r_poll <= '0;
        r_kind <= K_RST_LO; r_sh <= '0; r_ceb <= 1'b0; r_bitcnt <= '0;
        r_div <= '0; r_sclk <= 1'b0;
      end
      if (w_rise && r_state == S_FRAME) begin
        r_bitcnt <= r_bitcnt + BW'(1);
        // only status[1:0] matters; after 32 shifts these two bits hold it
        if (r_kind == K_POLL && r_bitcnt >= BW'(2)) r_status <= {r_status[0], i_spi_DOUT};
      end
      if (w_frame_end) begin
        r_ceb <= 1'b1; r_sh <= '0; r_gap <= '0; r_kind <= w_nkind;
        if (r_kind == K_POLL) begin
          if (w_st_ok) begin
            r_k <= w_k1; r_poll <= '0;
          end else begin
            r_poll <= r_poll + PW'(1);
            if (w_poll_max) r_err_index <= r_k;
          end
        end
        if (w_nkind == K_WR) begin
          r_mem_addr <= (r_kind == K_POLL) ? w_k1 : r_k;
          r_fetch    <= 2'b01;
        end
      end else if (r_state == S_FRAME && w_fall) begin
        r_sh <= {r_sh[FW-2:0], 1'b0};
      end
      if (r_state == S_GAP && w_fall) begin
        if (w_gap_end) begin
          r_sh <= w_frame; r_ceb <= 1'b0; r_bitcnt <= '0;
        end else begin
          r_gap <= r_gap + GW'(1);
        end
      end
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_err_index = r_err_index;
  assign o_spi_CEB   = r_ceb;
  assign o_spi_SCLK  = r_sclk;
  assign o_spi_DATA  = r_sh[FW-1];
endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench: a target model decodes SPI frames and a monitor checks them against
// an expected-frame queue filled by the stimulus.
module tb_spi_boot_loader;
  typedef struct { int nb; logic [65:0] bits; } frame_t;

  logic clk = 0, rst = 1, start = 0, dout = 0;
  logic [9:0]  nwords = '0;
  logic [31:0] base = '0, mem_rdata = '0;
  logic [9:0]  mem_addr, err_index;
  logic busy, done, err, ceb, sclk, sdata;

  logic [31:0] mem [4];
  logic [31:0] tgt_mem [4];
  logic [31:0] stat_q [$];
  frame_t      exp_q [$];
  bit          stuck = 0;
  int total = 0, bad = 0;
  int nb = 0, frames_started = 0;
  logic [65:0] fsh = '0;
  logic [31:0] cur_stat = '0;

  always #5 clk = ~clk;

  spi_boot_loader #(.sword(32), .NWORDS_W(10), .SCLK_DIV(2), .GAP_PER(4), .MAX_POLL(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_nwords(nwords), .i_base_addr(base),
    .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata), .o_busy(busy), .o_done(done),
    .o_err(err), .o_err_index(err_index), .o_spi_CEB(ceb), .o_spi_SCLK(sclk),
    .o_spi_DATA(sdata), .i_spi_DOUT(dout));

  always @(posedge clk) mem_rdata <= mem[mem_addr[1:0]];

  function automatic frame_t f_wr(input logic [31:0] a, input logic [31:0] d);
    frame_t f; f.nb = 66; f.bits = {2'b10, a, d}; return f;
  endfunction
  function automatic frame_t f_rst(input bit b);
    frame_t f; f.nb = 66; f.bits = {65'b0, b}; return f;
  endfunction
  function automatic frame_t f_poll();
    frame_t f; f.nb = 34; f.bits = '0; return f;
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // target side: shift in command bits, frame starts when CEB falls (SCLK is low then)
  always @(negedge ceb or posedge sclk) begin
    if (!ceb) begin
      if (sclk) begin
        fsh = {fsh[64:0], sdata};
        nb++;
      end else begin
        nb = 0; fsh = '0; frames_started++;
      end
    end
  end

  always @(negedge sclk) begin
    if (!ceb && nb >= 2 && nb <= 33) begin
      if (nb == 2) cur_stat = stuck ? 32'h1 : (stat_q.size() > 0 ? stat_q[0] : 32'h0);
      dout = cur_stat[33-nb];
    end
  end

  frame_t e_mon;
  always @(posedge ceb) begin
    if (!rst) begin
      if (nb == 34 && stat_q.size() > 0) void'(stat_q.pop_front());
      if (nb == 66 && fsh[65:64] == 2'b10) tgt_mem[fsh[33:32]] = fsh[31:0];
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL frame: unexpected %0d-bit frame %h", nb, fsh);
      end else begin
        e_mon = exp_q.pop_front();
        if (nb != e_mon.nb || fsh !== e_mon.bits) begin
          bad++;
          $display("FAIL frame: got %0d bits %h expected %0d bits %h", nb, fsh, e_mon.nb, e_mon.bits);
        end
      end
    end
  end

  // CEB-high gap between frames of one sequence must be 4 SCLK periods = 16 CLK
  logic prev_ceb = 1'b1;
  bit   gap_on = 0;
  int   gcnt = 0;
  always @(negedge clk) begin
    if (!busy) gap_on = 0;
    else if (ceb && !prev_ceb) begin gap_on = 1; gcnt = 1; end
    else if (ceb && gap_on) gcnt++;
    else if (!ceb && prev_ceb && gap_on) begin
      total++;
      if (gcnt != 16) begin bad++; $display("FAIL gap: got %0d cycles expected 16", gcnt); end
      gap_on = 0;
    end
    prev_ceb = ceb;
  end

  task automatic pulse_start(input logic [9:0] nw, input logic [31:0] b);
    nwords = nw; base = b; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_end(input string nm, input int limit);
    int n = 0;
    while (!(done || err) && n < limit) begin @(negedge clk); n++; end
    if (n >= limit) begin
      total++; bad++;
      $display("FAIL %s: timeout got busy=%0b expected done or err", nm, busy);
    end
  endtask

  initial begin
    int cnt, base_fs, n;
    logic seen;
    mem[0] = 32'hDEADBEEF; mem[1] = 32'h12345678; mem[2] = 32'h0000CAFE; mem[3] = 32'h0;
    repeat (4) @(negedge clk);
    chk("rst_ceb", ceb, 1); chk("rst_sclk", sclk, 0); chk("rst_data", sdata, 0);
    chk("rst_flags", {busy, done, err}, 0); chk("rst_erridx", err_index, 0);
    chk("rst_memaddr", mem_addr, 0);
    rst = 0;
    seen = 0;
    repeat (8) begin @(negedge clk); seen |= sclk; end
    chk("idle_sclk", seen, 0);

    // nwords=0: just the two CORE_RST frames, plus SCLK timing
    exp_q.push_back(f_rst(0)); exp_q.push_back(f_rst(1));
    pulse_start(10'd0, 32'h0);
    chk("ceb_fall", ceb, 0); chk("busy_on", busy, 1);
    cnt = 0;
    while (!sclk && cnt < 20) begin @(negedge clk); cnt++; end
    chk("first_rise", cnt, 2);
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (sclk && cnt < 20);
    do begin @(negedge clk); cnt++; end while (!sclk && cnt < 20);
    chk("sclk_period", cnt, 4);
    wait_end("nw0", 2000);
    chk("nw0_flags", {busy, done, err}, 3'b010); chk("nw0_q", exp_q.size(), 0);

    // three words, status always clear
    exp_q.push_back(f_rst(0));
    exp_q.push_back(f_wr(32'h0, 32'hDEADBEEF)); exp_q.push_back(f_poll());
    exp_q.push_back(f_wr(32'h1, 32'h12345678)); exp_q.push_back(f_poll());
    exp_q.push_back(f_wr(32'h2, 32'h0000CAFE)); exp_q.push_back(f_poll());
    exp_q.push_back(f_rst(1));
    pulse_start(10'd3, 32'h0);
    wait_end("nw3", 6000);
    chk("nw3_done", {busy, done, err}, 3'b010); chk("nw3_q", exp_q.size(), 0);
    chk("tgt0", tgt_mem[0], 32'hDEADBEEF); chk("tgt1", tgt_mem[1], 32'h12345678);
    chk("tgt2", tgt_mem[2], 32'h0000CAFE);

    // word 1 sees busy status twice before completing
    mem[0] = 32'h11111111; mem[1] = 32'h22222222; mem[2] = 32'h33333333;
    stat_q.push_back(32'h0); stat_q.push_back(32'h2); stat_q.push_back(32'h2); stat_q.push_back(32'h0);
    exp_q.push_back(f_rst(0));
    exp_q.push_back(f_wr(32'h0, 32'h11111111)); exp_q.push_back(f_poll());
    exp_q.push_back(f_wr(32'h1, 32'h22222222));
    exp_q.push_back(f_poll()); exp_q.push_back(f_poll()); exp_q.push_back(f_poll());
    exp_q.push_back(f_wr(32'h2, 32'h33333333)); exp_q.push_back(f_poll());
    exp_q.push_back(f_rst(1));
    pulse_start(10'd3, 32'h0);
    wait_end("retry", 8000);
    chk("retry_done", {busy, done, err}, 3'b010); chk("retry_q", exp_q.size(), 0);
    chk("retry_stat", stat_q.size(), 0);
    chk("retry_tgt1", tgt_mem[1], 32'h22222222); chk("retry_tgt2", tgt_mem[2], 32'h33333333);

    // stuck status -> timeout after 4 polls on word 0
    stuck = 1;
    exp_q.push_back(f_rst(0)); exp_q.push_back(f_wr(32'h0, 32'h11111111));
    repeat (4) exp_q.push_back(f_poll());
    pulse_start(10'd2, 32'h0);
    wait_end("stuck", 6000);
    chk("stuck_flags", {busy, done, err}, 3'b001); chk("stuck_idx", err_index, 0);
    chk("stuck_ceb", ceb, 1);
    seen = 0;
    repeat (400) begin @(negedge clk); seen |= sclk | ~ceb; end
    chk("stuck_quiet", seen, 0); chk("stuck_q", exp_q.size(), 0);
    stuck = 0;
    exp_q.push_back(f_rst(0)); exp_q.push_back(f_wr(32'h0, 32'h11111111));
    exp_q.push_back(f_poll()); exp_q.push_back(f_rst(1));
    pulse_start(10'd1, 32'h0);
    chk("restart_clr", {busy, done, err}, 3'b100);
    wait_end("restart", 4000);
    chk("restart_done", {busy, done, err}, 3'b010); chk("restart_q", exp_q.size(), 0);

    // reset in the middle of the first WRITE frame
    mem[0] = 32'hA5A5A5A5; mem[1] = 32'h5A5A5A5A;
    exp_q.push_back(f_rst(0));
    base_fs = frames_started;
    pulse_start(10'd2, 32'hFFFFFFFF);
    n = 0;
    while (!(frames_started == base_fs + 2 && nb == 20) && n < 3000) begin @(negedge clk); n++; end
    chk("abort_reach", n < 3000, 1);
    rst = 1;
    @(negedge clk);
    chk("abort_state", {ceb, busy, done, err}, 4'b1000); chk("abort_q", exp_q.size(), 0);
    rst = 0;

    // address wrap, with an ignored start while busy
    exp_q.push_back(f_rst(0));
    exp_q.push_back(f_wr(32'hFFFFFFFF, 32'hA5A5A5A5)); exp_q.push_back(f_poll());
    exp_q.push_back(f_wr(32'h00000000, 32'h5A5A5A5A)); exp_q.push_back(f_poll());
    exp_q.push_back(f_rst(1));
    pulse_start(10'd2, 32'hFFFFFFFF);
    repeat (100) @(negedge clk);
    pulse_start(10'd5, 32'h12345678);
    wait_end("wrap", 6000);
    chk("wrap_done", {busy, done, err}, 3'b010); chk("wrap_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
- Hardware firmware loader that sits directly upstream of the impl_axi SPI master port (spi_axi_master_CEB/SCLK/DATA/DOUT).
- Drives the SPI-to-AXI command protocol so that silicon boots without an external SPI host:
  - holds the picorv in reset;
  - streams N program words from a local ROM/memory read port to AXI addresses base_addr+k;
  - polls status after every write;
  - releases the picorv reset.
- Reports done or a poll-timeout error.

Parameters:
sword, 32, AXI data/address width carried in SPI frames
NWORDS_W, 10, width of word count and memory index (up to 1023 words)
SCLK_DIV, 2, CLK cycles per SCLK half-period (>=1)
GAP_PER, 4, SCLK periods CEB is held high between any two frames
MAX_POLL, 1024, status polls allowed per word before error

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; begins boot sequence when idle
nwords  in  NWORDS_W  number of words to load; sampled on accepted start
base_addr  in  sword  AXI address of word 0; sampled on accepted start
mem_addr  out  NWORDS_W  word index into program memory
mem_rdata  in  sword  program word; valid 1 CLK after mem_addr changes
busy  out  1  sequence in progress
done  out  1  sticky; set on successful completion, cleared on next accepted start
err  out  1  sticky; set on poll timeout, cleared on next accepted start
err_index  out  NWORDS_W  word index that timed out
spi_CEB  out  1  SPI chip enable, active low
spi_SCLK  out  1  SPI clock
spi_DATA  out  1  SPI command/data, MSB first
spi_DOUT  in  1  SPI read data from impl_axi

Behaviour:
- Reset values:
  - spi_CEB=1, spi_SCLK=0, spi_DATA=0;
  - busy=0, done=0, err=0, err_index=0, mem_addr=0;
  - FSM=IDLE.
  - RST mid-sequence aborts immediately to these values. Any frame being sent is not completed.
- SCLK:
  - Free-runs only while busy, 50% duty, period 2*SCLK_DIV CLK cycles.
  - Stops low in IDLE/DONE/ERR.
- Bit timing:
  - spi_DATA and spi_CEB change only on SCLK falling edges, or at SCLK start while SCLK is low.
  - The target samples spi_DATA on SCLK rising edges.
  - The loader samples spi_DOUT on SCLK rising edges.
- Frames (bits counted in SCLK rising edges, CEB low throughout):
  - WRITE: 66 bits = 2'b10, addr[31:0], data[31:0].
  - STATUS: 2'b00, then 32 bits captured from spi_DOUT into status[31:0], MSB first; spi_DATA=0 during capture. 34 bits total.
  - CORE_RST: 2'b00, 63 zeros, then 1 final bit = picorv reset value (0 = hold, 1 = run). 66 bits total.
- Between frames, CEB is high for exactly GAP_PER SCLK periods.
- FSM:
  - IDLE: start while idle → latch nwords/base_addr, clear done/err, busy=1 → RST_LO.
  - RST_LO: send CORE_RST with final bit 0 → GAP → FETCH (k=0), or RST_HI if nwords==0.
  - FETCH: mem_addr=k; wait 1 CLK; capture mem_rdata → WR.
  - WR: send WRITE, addr=base_addr+k (modulo 2^sword wrap), data=captured word → GAP → POLL.
  - POLL: send STATUS → GAP.
    - If status[1]==0 and status[0]==0: write complete → NEXT.
    - Else increment poll counter. If counter reaches MAX_POLL: err=1, err_index=k → ERR. Otherwise repeat POLL.
  - NEXT: k=k+1, reset poll counter. If k==nwords → RST_HI, else FETCH.
  - RST_HI: send CORE_RST with final bit 1 → DONE.
  - DONE: busy=0, done=1.
  - ERR: busy=0, err=1. The core stays held in reset because no RST_HI frame is sent.
  - From DONE and ERR, an accepted start restarts the sequence.
- start while busy is ignored, with no effect on the latched parameters.
- The memory port is read only in FETCH. mem_addr holds its value otherwise.
- start and RST in the same cycle: RST wins.

Test Plan:
- Reset → outputs at reset values, SCLK static low. Pulse start with SCLK_DIV=2 → first SCLK rising edge 2 CLK after CEB falls; SCLK period 4 CLK.
- nwords=0, start → exactly two 66-bit CORE_RST frames (last bit 0, then 1), 4-period CEB gap between them, done=1, busy=0.
- nwords=3, base_addr=0, mem={DEADBEEF,12345678,0000CAFE}, target status always 0 → frame sequence RST_LO, then (WR, POLL) ×3, then RST_HI. Decoded WR frames are 10|00000000|DEADBEEF, 10|00000001|12345678, 10|00000002|0000CAFE. done=1.
- Target returns status=0x00000002 twice, then 0x0 for word 1 → three STATUS frames for that word, then sequence continues; final memory contents match.
- status stuck at 0x00000001, MAX_POLL=4 → after 4 polls on word 0: err=1, err_index=0, done=0, no RST_HI frame, CEB=1, SCLK stopped. A following start re-runs the sequence from RST_LO.
- RST asserted mid-WR frame (bit 20) → next CLK CEB=1, busy=0; start pulsed during busy is ignored; base_addr=FFFFFFFF, nwords=2 → addresses FFFFFFFF then 00000000.
